// File: rtl/mod_mapper_pp_if.sv
// Stream/RAM-write bus of mod_mapper_pp: serial bits in with ready, scaled I/Q bank writes out.
// master = bit producer / RAM side, slave = the mapper.
interface mod_mapper_pp_if #(
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 11
);
  logic                         Bit_IN;
  logic                         Valid_IN;
  logic                         Last_IN;
  logic                         Ready_OUT;
  logic signed [OUT_WIDTH-1:0]  Mod_OUT_I;
  logic signed [OUT_WIDTH-1:0]  Mod_OUT_Q;
  logic                         write_enable;
  logic [ADDR_WIDTH-1:0]        Wr_addr;
  logic                         Bank_Sel;
  logic                         Bank_Done;
  logic [ADDR_WIDTH-1:0]        Bank_Fill;

  modport master (
    output Bit_IN, Valid_IN, Last_IN,
    input  Ready_OUT, Mod_OUT_I, Mod_OUT_Q, write_enable, Wr_addr,
           Bank_Sel, Bank_Done, Bank_Fill
  );

  modport slave (
    input  Bit_IN, Valid_IN, Last_IN,
    output Ready_OUT, Mod_OUT_I, Mod_OUT_Q, write_enable, Wr_addr,
           Bank_Sel, Bank_Done, Bank_Fill
  );
endinterface

// File: rtl/mod_mapper_pp.sv
// Serial-bit to Gray-mapped BPSK..256QAM mapper writing scaled I/Q into a ping-pong bank pair.
// Write appears 1 cycle after the last symbol bit; input stalls while the selected bank is busy.
module mod_mapper_pp #(
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_BITS  = 10,
  parameter int BANK_DEPTH = 1200,
  parameter int ADDR_WIDTH = 11
) (
  input  logic       CLK_Mod,
  input  logic       RST_Mod,
  input  logic       EN_Mod,
  input  logic [3:0] Order_Mod,
  input  logic       Bank_Release,
  input  logic       Release_Sel,
  output logic       Err_Order,
  mod_mapper_pp_if.slave bus
);

  localparam int AMP_W   = 5;
  localparam int SCALE_W = FRAC_BITS + 2;
  localparam int PROD_W  = AMP_W + SCALE_W;
  localparam int EXT_W   = (PROD_W > OUT_WIDTH) ? PROD_W : OUT_WIDTH;

  // round(2^FRAC_BITS / sqrt(norm)) for norm = 2, 10, 42, 170
  localparam int SC_QPSK = $rtoi($itor(1 << FRAC_BITS) / 1.4142135624 + 0.5);
  localparam int SC_16   = $rtoi($itor(1 << FRAC_BITS) / 3.1622776602 + 0.5);
  localparam int SC_64   = $rtoi($itor(1 << FRAC_BITS) / 6.4807406984 + 0.5);
  localparam int SC_256  = $rtoi($itor(1 << FRAC_BITS) / 13.038404810 + 0.5);

  localparam logic signed [EXT_W-1:0] OUT_MAX =
    {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN =
    {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // a[0] is the sign bit of the axis, a[3:1] the successive refinement bits
  function automatic logic signed [AMP_W-1:0] axis_amp(input logic [3:0] ord,
                                                       input logic [3:0] a);
    int s0, s1, s2, s3, v;
    s0 = a[0] ? -1 : 1;
    s1 = a[1] ? -1 : 1;
    s2 = a[2] ? -1 : 1;
    s3 = a[3] ? -1 : 1;
    case (ord)
      4'd4:    v = 2 - s1;
      4'd6:    v = 4 - s1 * (2 - s2);
      4'd8:    v = 8 - s1 * (4 - s2 * (2 - s3));
      default: v = 1;
    endcase
    return AMP_W'(s0 * v);
  endfunction

  function automatic logic signed [SCALE_W-1:0] scale_of(input logic [3:0] ord);
    case (ord)
      4'd4:    return SCALE_W'(SC_16);
      4'd6:    return SCALE_W'(SC_64);
      4'd8:    return SCALE_W'(SC_256);
      default: return SCALE_W'(SC_QPSK);
    endcase
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [PROD_W-1:0] p);
    logic signed [EXT_W-1:0] x;
    x = EXT_W'(p);
    if (x > OUT_MAX)      return OUT_MAX[OUT_WIDTH-1:0];
    else if (x < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    return x[OUT_WIDTH-1:0];
  endfunction

  logic [2:0]                   cnt_q;
  logic [3:0]                   ord_q;
  logic [7:0]                   sym_q;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [ADDR_WIDTH-1:0]        wr_addr_q;
  logic [ADDR_WIDTH-1:0]        fill_q;
  logic                         bank_q;
  logic [1:0]                   busy_q;
  logic [1:0]                   busy_nxt;
  logic                         we_q;
  logic                         done_q;
  logic                         err_q;
  logic signed [OUT_WIDTH-1:0]  out_i_q;
  logic signed [OUT_WIDTH-1:0]  out_q_q;

  logic                         ready;
  logic                         accept;
  logic                         commit;
  logic                         first;
  logic                         illegal;
  logic                         sym_end;
  logic                         close;
  logic [3:0]                   ord_in;
  logic [3:0]                   ord_cur;
  logic [7:0]                   bits_cur;
  logic signed [AMP_W-1:0]      amp_i;
  logic signed [AMP_W-1:0]      amp_q;
  logic signed [PROD_W-1:0]     prod_i;
  logic signed [PROD_W-1:0]     prod_q;
  logic signed [PROD_W-1:0]     scale_x;

  assign ready  = RST_Mod && EN_Mod && !busy_q[bank_q];
  assign accept = bus.Valid_IN && ready;
  assign commit = we_q && EN_Mod;

  always_comb begin
    illegal  = !(Order_Mod inside {4'd1, 4'd2, 4'd4, 4'd6, 4'd8});
    ord_in   = illegal ? 4'd2 : Order_Mod;
    first    = (cnt_q == 3'd0);
    ord_cur  = first ? ord_in : ord_q;
    bits_cur = first ? 8'd0 : sym_q;
    bits_cur[cnt_q] = bus.Bit_IN;
    // Last_IN ends the symbol early; unreceived bits stay zero from bits_cur
    sym_end  = ({1'b0, cnt_q} == (ord_cur - 4'd1)) || bus.Last_IN;
    close    = (addr_q == ADDR_WIDTH'(BANK_DEPTH - 1)) || bus.Last_IN;
  end

  always_comb begin
    if (ord_cur == 4'd1) begin
      amp_i = axis_amp(ord_cur, {3'b000, bits_cur[0]});
      amp_q = axis_amp(ord_cur, {3'b000, bits_cur[0]});
    end else begin
      amp_i = axis_amp(ord_cur, {bits_cur[6], bits_cur[4], bits_cur[2], bits_cur[0]});
      amp_q = axis_amp(ord_cur, {bits_cur[7], bits_cur[5], bits_cur[3], bits_cur[1]});
    end
    scale_x = PROD_W'(scale_of(ord_cur));
    prod_i  = PROD_W'(amp_i) * scale_x;
    prod_q  = PROD_W'(amp_q) * scale_x;
  end

  always_ff @(posedge CLK_Mod or negedge RST_Mod) begin
    if (!RST_Mod) begin
      cnt_q     <= '0;
      ord_q     <= '0;
      sym_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      fill_q    <= '0;
      bank_q    <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      out_i_q   <= '0;
      out_q_q   <= '0;
    end else if (EN_Mod) begin
      // The bank flips only once its closing write has actually been presented
      if (commit) begin
        we_q   <= 1'b0;
        done_q <= 1'b0;
        if (done_q) bank_q <= ~bank_q;
      end
      if (accept) begin
        if (first) begin
          ord_q <= ord_in;
          if (illegal) err_q <= 1'b1;
        end
        if (sym_end) begin
          cnt_q     <= '0;
          sym_q     <= '0;
          out_i_q   <= sat(prod_i);
          out_q_q   <= sat(prod_q);
          wr_addr_q <= addr_q;
          we_q      <= 1'b1;
          done_q    <= close;
          fill_q    <= addr_q + 1'b1;
          addr_q    <= close ? '0 : addr_q + 1'b1;
        end else begin
          cnt_q <= cnt_q + 3'd1;
          sym_q <= bits_cur;
        end
      end
    end
  end

  // Release is honoured even while disabled so a consumer pulse is never lost
  always_comb begin
    busy_nxt = busy_q;
    if (Bank_Release) busy_nxt[Release_Sel] = 1'b0;
    if (commit && done_q) busy_nxt[bank_q] = 1'b1;
  end

  always_ff @(posedge CLK_Mod or negedge RST_Mod) begin
    if (!RST_Mod) busy_q <= '0;
    else          busy_q <= busy_nxt;
  end

  assign bus.Ready_OUT    = ready;
  assign bus.Mod_OUT_I    = out_i_q;
  assign bus.Mod_OUT_Q    = out_q_q;
  assign bus.write_enable = commit;
  assign bus.Wr_addr      = we_q ? wr_addr_q : addr_q;
  assign bus.Bank_Sel     = bank_q;
  assign bus.Bank_Done    = commit && done_q;
  assign bus.Bank_Fill    = fill_q;
  assign Err_Order        = err_q;

endmodule

// File: tb/tb_mod_mapper_pp.sv
// Scoreboard bench for mod_mapper_pp: a reference model queues every expected write and bank close.
`timescale 1ns/1ps
module tb_mod_mapper_pp;
  localparam int OW = 16, FB = 10, DEPTH = 1200, AW = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rel = 1'b0;
  logic       rel_sel = 1'b0;
  logic [3:0] order = 4'd2;
  logic       err;

  mod_mapper_pp_if #(.OUT_WIDTH(OW), .ADDR_WIDTH(AW)) bus ();

  mod_mapper_pp #(.OUT_WIDTH(OW), .FRAC_BITS(FB), .BANK_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .CLK_Mod      (clk),
    .RST_Mod      (rst_n),
    .EN_Mod       (en),
    .Order_Mod    (order),
    .Bank_Release (rel),
    .Release_Sel  (rel_sel),
    .Err_Order    (err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int i; int q; int addr; int bank; } wr_t;
  wr_t wr_q[$];
  int  done_q[$];
  int  n_tests = 0;
  int  n_fail = 0;

  int         m_cnt, m_ord, m_addr, m_bank;
  logic [7:0] m_bits;

  task automatic check(input string tag, input integer got, input integer exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int scale_of(input int ord);
    case (ord)
      4:       return 324;
      6:       return 158;
      8:       return 79;
      default: return 724;
    endcase
  endfunction

  // Gray-coded PAM magnitudes indexed by the refinement bits, MSB first
  function automatic int exp_axis(input int ord, input logic [7:0] b, input int ax);
    int t16[2]  = '{1, 3};
    int t64[4]  = '{3, 1, 5, 7};
    int t256[8] = '{5, 7, 3, 1, 11, 9, 13, 15};
    int sgn, mag;
    if (ord == 1) return b[0] ? -1 : 1;
    sgn = b[ax] ? -1 : 1;
    case (ord)
      4:       mag = t16[b[ax+2]];
      6:       mag = t64[{b[ax+2], b[ax+4]}];
      8:       mag = t256[{b[ax+2], b[ax+4], b[ax+6]}];
      default: mag = 1;
    endcase
    return sgn * mag;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ord = 2; m_addr = 0; m_bank = 0; m_bits = '0;
    wr_q.delete();
    done_q.delete();
  endtask

  task automatic model_accept(input logic b, input logic last);
    wr_t w;
    if (m_cnt == 0) begin
      m_ord  = (order inside {4'd1, 4'd2, 4'd4, 4'd6, 4'd8}) ? int'(order) : 2;
      m_bits = '0;
    end
    m_bits[m_cnt] = b;
    if (m_cnt == m_ord - 1 || last) begin
      w.i    = exp_axis(m_ord, m_bits, 0) * scale_of(m_ord);
      w.q    = exp_axis(m_ord, m_bits, 1) * scale_of(m_ord);
      w.addr = m_addr;
      w.bank = m_bank;
      wr_q.push_back(w);
      if (m_addr == DEPTH - 1 || last) begin
        done_q.push_back(m_addr + 1);
        m_addr = 0;
        m_bank ^= 1;
      end else begin
        m_addr++;
      end
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_bit(input logic b, input logic last);
    bit acc;
    acc = 1'b0;
    bus.Bit_IN = b; bus.Valid_IN = 1'b1; bus.Last_IN = last;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = (bus.Ready_OUT === 1'b1) && (en === 1'b1);
      @(posedge clk);
    end
    if (acc) model_accept(b, last);
    else     check("ready_wait", bus.Ready_OUT, 1);
    #1;
    bus.Valid_IN = 1'b0; bus.Last_IN = 1'b0;
  endtask

  task automatic send_sym(input logic [3:0] ord, input logic [7:0] bits, input int n,
                          input logic last_end);
    order = ord;
    for (int i = 0; i < n; i++) send_bit(bits[i], last_end && (i == n - 1));
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic check_io(input string tag, input int i, input int q);
    check({tag, "_i"}, $signed(bus.Mod_OUT_I), i);
    check({tag, "_q"}, $signed(bus.Mod_OUT_Q), q);
  endtask

  wr_t mon_w;
  int  mon_f;
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      if (wr_q.size() == 0) check("wr_unexpected", wr_q.size(), 1);
      else begin
        mon_w = wr_q.pop_front();
        check("sb_i", $signed(bus.Mod_OUT_I), mon_w.i);
        check("sb_q", $signed(bus.Mod_OUT_Q), mon_w.q);
        check("sb_addr", bus.Wr_addr, mon_w.addr);
        check("sb_bank", bus.Bank_Sel, mon_w.bank);
      end
    end
    if (bus.Bank_Done === 1'b1) begin
      if (done_q.size() == 0) check("done_unexpected", done_q.size(), 1);
      else begin
        mon_f = done_q.pop_front();
        check("sb_fill", bus.Bank_Fill, mon_f);
      end
    end
  end

  initial begin
    bus.Bit_IN = 1'b0; bus.Valid_IN = 1'b0; bus.Last_IN = 1'b0;
    model_reset();
    #2;
    check("rst_i", bus.Mod_OUT_I, 0);
    check("rst_we", bus.write_enable, 0);
    check("rst_addr", bus.Wr_addr, 0);
    check("rst_sel", bus.Bank_Sel, 0);
    check("rst_done", bus.Bank_Done, 0);
    check("rst_err", err, 0);
    #20;
    rst_n = 1'b1;
    en = 1'b1;
    sync();
    check("rdy_after_rst", bus.Ready_OUT, 1);

    // QPSK with latency probe
    order = 4'd2;
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    check("we_early", bus.write_enable, 0);
    sync();
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    check("we_lat", bus.write_enable, 1);
    check("qpsk01_addr", bus.Wr_addr, 0);
    check_io("qpsk01", 724, -724);
    sync();
    send_sym(4'd2, 8'b0000_0011, 2, 1'b0);
    @(negedge clk); check_io("qpsk11", -724, -724); sync();
    send_sym(4'd4, 8'b0000_1100, 4, 1'b0);
    @(negedge clk); check_io("qam16", 972, 972); sync();
    send_sym(4'd8, 8'b0000_0000, 8, 1'b0);
    @(negedge clk); check_io("qam256", 395, 395); sync();
    send_sym(4'd1, 8'b0000_0001, 1, 1'b0);
    @(negedge clk); check_io("bpsk1", -724, -724); sync();

    for (int r = 0; r < 4; r++) begin
      send_sym(4'd4, 8'($urandom_range(0, 255)), 4, 1'b0);
      send_sym(4'd6, 8'($urandom_range(0, 255)), 6, 1'b0);
      send_sym(4'd8, 8'($urandom_range(0, 255)), 8, 1'b0);
    end

    // Illegal order falls back to QPSK
    send_sym(4'd5, 8'b0000_0001, 2, 1'b0);
    @(negedge clk);
    check("err_order", err, 1);
    check_io("illegal", -724, 724);
    sync();

    // Freeze mid-symbol
    order = 4'd4;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    en = 1'b0;
    bus.Valid_IN = 1'b1; bus.Bit_IN = 1'b1;
    repeat (10) @(negedge clk);
    check("frz_we", bus.write_enable, 0);
    check("frz_rdy", bus.Ready_OUT, 0);
    check("frz_addr", bus.Wr_addr, m_addr);
    sync();
    bus.Valid_IN = 1'b0;
    en = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk); check_io("frz_sym", -972, 972); sync();

    // Partial 64QAM symbol closes bank 0
    order = 4'd6;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    @(negedge clk);
    check_io("pad64", -790, 474);
    check("pad_done", bus.Bank_Done, 1);
    sync();
    check("sel_after_pad", bus.Bank_Sel, 1);

    // Fill bank 1 completely while bank 0 is still busy
    for (int s = 0; s < DEPTH; s++) send_sym(4'd2, 8'($urandom_range(0, 3)), 2, 1'b0);
    @(negedge clk);
    check("full_done", bus.Bank_Done, 1);
    check("full_fill", bus.Bank_Fill, 1200);
    check("rdy_at_done", bus.Ready_OUT, 1);
    @(negedge clk);
    check("rdy_stall", bus.Ready_OUT, 0);
    check("sel_after_full", bus.Bank_Sel, 0);
    repeat (5) @(negedge clk);
    check("rdy_still_stall", bus.Ready_OUT, 0);
    sync();
    rel = 1'b1; rel_sel = 1'b0;
    sync();
    rel = 1'b0;
    @(negedge clk);
    check("rdy_released", bus.Ready_OUT, 1);
    sync();
    send_sym(4'd2, 8'b0000_0010, 2, 1'b0);
    @(negedge clk);
    check("new_bank_addr", bus.Wr_addr, 0);
    check_io("new_bank", 724, -724);
    sync();

    // Release bank 1, then close bank 0 on a symbol boundary
    rel = 1'b1; rel_sel = 1'b1;
    sync();
    rel = 1'b0;
    send_sym(4'd2, 8'b0000_0001, 2, 1'b1);
    @(negedge clk);
    check("bnd_fill", bus.Bank_Fill, 2);
    sync();
    check("sel_before_rst", bus.Bank_Sel, 1);

    // Asynchronous reset mid-symbol
    order = 4'd2;
    send_bit(1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_i", bus.Mod_OUT_I, 0);
    check("arst_q", bus.Mod_OUT_Q, 0);
    check("arst_sel", bus.Bank_Sel, 0);
    check("arst_fill", bus.Bank_Fill, 0);
    check("arst_err", err, 0);
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    sync();
    send_sym(4'd2, 8'b0000_0000, 2, 1'b0);
    @(negedge clk);
    check("post_rst_addr", bus.Wr_addr, 0);
    check_io("post_rst", 724, 724);
    repeat (3) sync();
    check("sb_left", wr_q.size() + done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
